clint: RTL and testbench

- Core-local interrupt/trap controller, directly upstream of the CSR register file.
- Detects synchronous traps (ecall, ebreak) and asynchronous timer interrupts, and detects mret from the decode-stage instruction.
- Holds the pipeline, sequentially writes mepc/mcause/mstatus through the CSR file's clint write port, then redirects the PC to mtvec (trap) or mepc (mret).

---
 rtl/clint_pkg.sv | 39 +++
 rtl/clint_if.sv | 24 ++
 rtl/clint.sv | 145 ++++++++++++++
 tb/tb_clint.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt controller: CSR addresses, instruction
// encodings, trap causes and the mstatus update helpers.
package clint_pkg;

    localparam logic [31:0] MCAUSE_TIMER  = 32'h8000_0007;
    localparam logic [31:0] MCAUSE_ECALL  = 32'd11;
    localparam logic [31:0] MCAUSE_EBREAK = 32'd3;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;

    // Trap entry: MPIE <- MIE, MIE <- 0.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // Trap return: MIE <- MPIE, MPIE <- 1.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r               = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint_if.sv
// Link between the interrupt controller and the CSR register file: the clint write port
// plus the CSR values and ex-stage write activity the controller needs to see.
interface clint_if;

    logic        clint_we;
    logic [31:0] clint_waddr;
    logic [31:0] clint_wdata;
    logic        csr_ex_we;
    logic [31:0] csr_mtvec;
    logic [31:0] csr_mepc;
    logic [31:0] csr_mstatus;
    logic        global_int_en;

    modport master (
        output clint_we, clint_waddr, clint_wdata,
        input  csr_ex_we, csr_mtvec, csr_mepc, csr_mstatus, global_int_en
    );

    modport slave (
        input  clint_we, clint_waddr, clint_wdata,
        output csr_ex_we, csr_mtvec, csr_mepc, csr_mstatus, global_int_en
    );

endinterface

// File: rtl/clint.sv
// Core-local interrupt controller: detects ecall/ebreak/timer irq/mret, sequences the
// mepc/mcause/mstatus CSR writes and redirects the PC. Define CLINT_EBREAK_EN to trap on ebreak.
module clint
    import clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        irq_i,
    clint_if.master     csr,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    typedef enum logic [2:0] {
        StIdle, StMepc, StMcause, StMstatus, StAssert, StMret, StMretAssert
    } state_e;

    state_e      state_q, state_d;
    logic        irq_pend_q, irq_pend_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] cause_q, cause_d;
    logic        is_ecall, is_ebreak, is_mret, is_irq;
    logic        we;
    logic [31:0] waddr, wdata;

    always_comb begin
        is_ecall = (inst_i == INST_ECALL);
`ifdef CLINT_EBREAK_EN
        is_ebreak = (inst_i == INST_EBREAK);
`else
        is_ebreak = 1'b0;
`endif
        is_mret = (inst_i == INST_MRET);
        is_irq  = irq_pend_q & csr.global_int_en;
    end

    always_comb begin
        state_d      = state_q;
        mepc_d       = mepc_q;
        cause_d      = cause_q;
        irq_pend_d   = irq_pend_q | (irq_i & csr.global_int_en);
        we           = 1'b0;
        waddr        = 32'h0;
        wdata        = 32'h0;
        hold_flag_o  = 1'b0;
        int_assert_o = 1'b0;
        int_addr_o   = 32'h0;

        case (state_q)
            StIdle: begin
                if (is_ecall) begin
                    cause_d = MCAUSE_ECALL;
                    mepc_d  = inst_addr_i;
                    state_d = StMepc;
                end else if (is_ebreak) begin
                    cause_d = MCAUSE_EBREAK;
                    mepc_d  = inst_addr_i;
                    state_d = StMepc;
                end else if (is_irq) begin
                    // A redirecting ex stage means inst_addr_i is on the wrong path.
                    cause_d    = MCAUSE_TIMER;
                    mepc_d     = jump_flag_i ? jump_addr_i : inst_addr_i;
                    irq_pend_d = 1'b0;
                    state_d    = StMepc;
                end else if (is_mret) begin
                    state_d = StMret;
                end
                hold_flag_o = is_ecall | is_ebreak | is_irq | is_mret;
            end
            StMepc, StMcause, StMstatus, StMret: begin
                hold_flag_o = 1'b1;
                // The ex stage owns the CSR port this cycle; retry next cycle.
                if (!csr.csr_ex_we) begin
                    we = 1'b1;
                    unique case (state_q)
                        StMepc: begin
                            waddr   = {20'h0, CSR_MEPC};
                            wdata   = mepc_q;
                            state_d = StMcause;
                        end
                        StMcause: begin
                            waddr   = {20'h0, CSR_MCAUSE};
                            wdata   = cause_q;
                            state_d = StMstatus;
                        end
                        StMstatus: begin
                            waddr   = {20'h0, CSR_MSTATUS};
                            wdata   = mstatus_on_trap(csr.csr_mstatus);
                            state_d = StAssert;
                        end
                        default: begin
                            waddr   = {20'h0, CSR_MSTATUS};
                            wdata   = mstatus_on_mret(csr.csr_mstatus);
                            state_d = StMretAssert;
                        end
                    endcase
                end
            end
            StAssert: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr.csr_mtvec;
                state_d      = StIdle;
            end
            StMretAssert: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr.csr_mepc;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (rst) begin
            we           = 1'b0;
            waddr        = 32'h0;
            wdata        = 32'h0;
            hold_flag_o  = 1'b0;
            int_assert_o = 1'b0;
            int_addr_o   = 32'h0;
        end
    end

    assign csr.clint_we    = we;
    assign csr.clint_waddr = waddr;
    assign csr.clint_wdata = wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            irq_pend_q <= 1'b0;
            mepc_q     <= 32'h0;
            cause_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            irq_pend_q <= irq_pend_d;
            mepc_q     <= mepc_d;
            cause_q    <= cause_d;
        end
    end

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: expected CSR writes and PC redirects are queued as stimulus is
// driven and popped whenever the DUT produces them.
module tb_clint;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] MTVEC  = 32'h0000_0080;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i, int_addr_o;
    logic        jump_flag_i, irq_i, hold_flag_o, int_assert_o;

    wr_t         wr_q[$];
    logic [31:0] rd_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    clint_if bus ();

    clint dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .irq_i        (irq_i),
        .csr          (bus),
        .hold_flag_o  (hold_flag_o),
        .int_assert_o (int_assert_o),
        .int_addr_o   (int_addr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle after the inputs changed at posedge+1.
    task automatic sample();
        #2;
    endtask

    // Retire any DUT write/redirect against the scoreboard, then move to the next cycle.
    task automatic advance();
        wr_t         e;
        logic [31:0] r;
        if (bus.clint_we) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'(bus.clint_we), 32'd0);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", bus.clint_waddr, e.a);
                check("wr_data", bus.clint_wdata, e.d);
            end
        end
        if (int_assert_o) begin
            if (rd_q.size() == 0) begin
                check("unexpected_redirect", 32'(int_assert_o), 32'd0);
            end else begin
                r = rd_q.pop_front();
                check("redirect_addr", int_addr_o, r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wr_drained"}, 32'(wr_q.size()), 32'd0);
        check({tag, "_rd_drained"}, 32'(rd_q.size()), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_we"}, 32'(bus.clint_we), 32'd0);
        check({tag, "_hold"}, 32'(hold_flag_o), 32'd0);
        check({tag, "_assert"}, 32'(int_assert_o), 32'd0);
        check({tag, "_waddr"}, bus.clint_waddr, 32'd0);
        check({tag, "_wdata"}, bus.clint_wdata, 32'd0);
        check({tag, "_int_addr"}, int_addr_o, 32'd0);
    endtask

    function automatic logic [31:0] ms_trap(input logic [31:0] s);
        logic [31:0] r;
        r = s & ~32'h0000_0088;
        if (s[3]) r = r | 32'h0000_0080;
        return r;
    endfunction

    function automatic logic [31:0] ms_mret(input logic [31:0] s);
        logic [31:0] r;
        r = (s & ~32'h0000_0008) | 32'h0000_0080;
        if (s[7]) r = r | 32'h0000_0008;
        return r;
    endfunction

    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] ms);
        wr_q.push_back('{a: 32'h341, d: pc});
        wr_q.push_back('{a: 32'h342, d: cause});
        wr_q.push_back('{a: 32'h300, d: ms_trap(ms)});
        rd_q.push_back(MTVEC);
    endtask

    // Nominal synchronous trap: detect, three writes, redirect on cycle 4.
    task automatic run_trap(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] cause, input logic [31:0] ms);
        bus.csr_mstatus = ms;
        push_trap(pc, cause, ms);
        inst_i      = inst;
        inst_addr_i = pc;
        sample();
        check({tag, "_detect_hold"}, 32'(hold_flag_o), 32'd1);
        check({tag, "_detect_we"}, 32'(bus.clint_we), 32'd0);
        advance();
        inst_i = NOP;
        for (int i = 1; i <= 3; i++) begin
            sample();
            check({tag, "_seq_hold"}, 32'(hold_flag_o), 32'd1);
            check({tag, "_seq_we"}, 32'(bus.clint_we), 32'd1);
            check({tag, "_seq_assert"}, 32'(int_assert_o), 32'd0);
            advance();
        end
        sample();
        check({tag, "_c4_assert"}, 32'(int_assert_o), 32'd1);
        check({tag, "_c4_hold"}, 32'(hold_flag_o), 32'd0);
        advance();
        sample();
        check({tag, "_after_hold"}, 32'(hold_flag_o), 32'd0);
        check_drained(tag);
    endtask

    initial begin
        rst               = 1'b1;
        inst_i            = NOP;
        inst_addr_i       = 32'h0;
        jump_flag_i       = 1'b0;
        jump_addr_i       = 32'h0;
        irq_i             = 1'b0;
        bus.csr_ex_we     = 1'b0;
        bus.csr_mtvec     = MTVEC;
        bus.csr_mepc      = 32'h0;
        bus.csr_mstatus   = 32'h8;
        bus.global_int_en = 1'b0;
        @(posedge clk);
        #1;
        // Outputs held at 0 under reset even with an ecall in decode.
        inst_i = ECALL;
        sample();
        check_quiet("reset");
        advance();
        inst_i = NOP;
        rst    = 1'b0;
        sample();
        check_quiet("idle");
        advance();

        run_trap("ecall", ECALL, 32'h100, 32'd11, 32'h8);

        // Timer irq while ex is redirecting: mepc takes the jump target.
        bus.global_int_en = 1'b1;
        irq_i             = 1'b1;
        jump_flag_i       = 1'b1;
        jump_addr_i       = 32'h200;
        inst_addr_i       = 32'h1fc;
        sample();
        check("irq_pend_latency_hold", 32'(hold_flag_o), 32'd0);
        advance();
        irq_i = 1'b0;
        push_trap(32'h200, 32'h8000_0007, 32'h8);
        sample();
        check("irq_detect_hold", 32'(hold_flag_o), 32'd1);
        advance();
        jump_flag_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            sample();
            check("irq_pend_cleared_hold", 32'(hold_flag_o), 32'd0);
            check("irq_pend_cleared_we", 32'(bus.clint_we), 32'd0);
            advance();
        end
        check_drained("irq");

        // Interrupts masked: the request must neither trap nor stay pending.
        bus.global_int_en = 1'b0;
        irq_i             = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("masked_hold", 32'(hold_flag_o), 32'd0);
            check("masked_we", 32'(bus.clint_we), 32'd0);
            advance();
        end
        irq_i             = 1'b0;
        bus.global_int_en = 1'b1;
        sample();
        check("masked_no_pend", 32'(hold_flag_o), 32'd0);
        advance();
        check_drained("masked");

        // mret: mstatus rewrite then redirect to mepc.
        bus.csr_mepc    = 32'h104;
        bus.csr_mstatus = 32'h80;
        wr_q.push_back('{a: 32'h300, d: ms_mret(32'h80)});
        rd_q.push_back(32'h104);
        inst_i = MRET;
        sample();
        check("mret_detect_hold", 32'(hold_flag_o), 32'd1);
        check("mret_detect_we", 32'(bus.clint_we), 32'd0);
        advance();
        inst_i = NOP;
        sample();
        check("mret_write_we", 32'(bus.clint_we), 32'd1);
        check("mret_write_hold", 32'(hold_flag_o), 32'd1);
        advance();
        sample();
        check("mret_assert", 32'(int_assert_o), 32'd1);
        check("mret_assert_hold", 32'(hold_flag_o), 32'd0);
        advance();
        sample();
        check("mret_after_hold", 32'(hold_flag_o), 32'd0);
        check_drained("mret");

        // ex-stage CSR write collides with S_MCAUSE for two cycles.
        bus.csr_mstatus = 32'h8;
        push_trap(32'h300, 32'd11, 32'h8);
        inst_i      = ECALL;
        inst_addr_i = 32'h300;
        sample();
        advance();
        inst_i = NOP;
        sample();
        check("coll_mepc_we", 32'(bus.clint_we), 32'd1);
        advance();
        bus.csr_ex_we = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("coll_blocked_we", 32'(bus.clint_we), 32'd0);
            check("coll_blocked_hold", 32'(hold_flag_o), 32'd1);
            advance();
        end
        bus.csr_ex_we = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            check("coll_retry_we", 32'(bus.clint_we), 32'd1);
            check("coll_retry_assert", 32'(int_assert_o), 32'd0);
            advance();
        end
        sample();
        check("coll_late_assert", 32'(int_assert_o), 32'd1);
        advance();
        check_drained("coll");

        // Reset in S_MCAUSE abandons the sequence; mepc write already stands.
        wr_q.push_back('{a: 32'h341, d: 32'h400});
        inst_i      = ECALL;
        inst_addr_i = 32'h400;
        sample();
        advance();
        inst_i = NOP;
        sample();
        advance();
        sample();
        check("rstmid_pre_we", 32'(bus.clint_we), 32'd1);
        rst = 1'b1;
        #1;
        check_quiet("rstmid");
        advance();
        sample();
        check_quiet("rstmid_held");
        advance();
        rst = 1'b0;
        sample();
        check_quiet("rstmid_release");
        advance();
        check_drained("rstmid");
        run_trap("post_rst_ecall", ECALL, 32'h500, 32'd11, 32'h8);

`ifdef CLINT_EBREAK_EN
        run_trap("ebreak", EBREAK, 32'h600, 32'd3, 32'h8);
`else
        inst_i      = EBREAK;
        inst_addr_i = 32'h600;
        sample();
        check("ebreak_nop_hold", 32'(hold_flag_o), 32'd0);
        advance();
        sample();
        check("ebreak_nop_we", 32'(bus.clint_we), 32'd0);
        advance();
        inst_i = NOP;
        check_drained("ebreak");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
